// File: rtl/ddr_lane_engine.sv
// Note-lane engine: spawns arrows from an LFSR, scrolls them each frame,
// judges button presses against the target row, and keeps score and combo.
module ddr_lane_engine #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned SLOTS        = 4,
    parameter int unsigned CORDW        = 10,
    parameter int unsigned LANE_X0      = 160,
    parameter int unsigned LANE_PITCH   = 96,
    parameter int unsigned ARROW_W      = 64,
    parameter int unsigned ARROW_H      = 32,
    parameter int unsigned TARGET_Y     = 400,
    parameter int unsigned HIT_WIN      = 16,
    parameter int unsigned PERF_WIN     = 4,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned SPAWN_PERIOD = 30,
    parameter int unsigned SCOREW       = 16,
    parameter int unsigned COMBOW       = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CORDW-1:0]         sx_i,
    input  logic [CORDW-1:0]         sy_i,
    input  logic                     frame_i,
    input  logic                     enable_i,
    input  logic [LANES-1:0]         btn_i,
    output logic [LANES*SLOTS-1:0]   arrow_o,
    output logic                     target_o,
    output logic [LANES-1:0]         hit_o,
    output logic [LANES-1:0]         boo_o,
    output logic [LANES-1:0]         miss_o,
    output logic                     spawn_o,
    output logic [2:0]               spawn_lane_o,
    output logic                     drop_o,
    output logic [SCOREW-1:0]        score_o,
    output logic [COMBOW-1:0]        combo_o
);

    localparam int unsigned NSLOT = LANES * SLOTS;
    localparam int unsigned CNTW  = $clog2(SPAWN_PERIOD + 1);
    localparam int unsigned PTSW  = $clog2(3 * LANES + 1);
    localparam int unsigned HITW  = $clog2(LANES + 1);
    localparam logic [CORDW:0]  TY       = (CORDW+1)'(TARGET_Y);
    localparam logic [CORDW:0]  MISS_Y   = (CORDW+1)'(TARGET_Y + HIT_WIN);
    localparam logic [CORDW:0]  SPD      = (CORDW+1)'(SPEED);
    localparam logic [CORDW:0]  HWIN     = (CORDW+1)'(HIT_WIN);
    localparam logic [CORDW:0]  PWIN     = (CORDW+1)'(PERF_WIN);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SPAWN_PERIOD - 1);

    logic [NSLOT-1:0]  r_valid;
    logic [CORDW-1:0]  r_y [NSLOT];
    logic [CNTW-1:0]   r_cnt;
    logic [15:0]       r_lfsr;
    logic [SCOREW-1:0] r_score;
    logic [COMBOW-1:0] r_combo;
    logic [LANES-1:0]  r_hit, r_boo, r_miss;
    logic              r_spawn, r_drop;
    logic [2:0]        r_spawn_lane;

    logic [NSLOT-1:0]  w_valid_nxt;
    logic [CORDW-1:0]  w_y_nxt [NSLOT];
    logic [CNTW-1:0]   w_cnt_nxt;
    logic [15:0]       w_lfsr_nxt;
    logic [LANES-1:0]  w_hit, w_boo, w_miss;
    logic              w_spawn, w_drop, w_found, w_placed;
    logic [2:0]        w_lane;
    logic [PTSW-1:0]   w_pts;
    logic [HITW-1:0]   w_nhit;
    logic [CORDW:0]    w_yext, w_d;
    logic [SCOREW:0]   w_score_sum;
    logic [COMBOW:0]   w_combo_sum;
    logic [SCOREW-1:0] w_score_nxt;
    logic [COMBOW-1:0] w_combo_nxt;
    logic [LANES-1:0]  w_in_lane;

    // Judge presses on pre-scroll positions, then scroll and spawn on frame
    always_comb begin
        w_valid_nxt = r_valid;
        w_y_nxt     = r_y;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_hit       = '0;
        w_boo       = '0;
        w_miss      = '0;
        w_spawn     = 1'b0;
        w_drop      = 1'b0;
        w_found     = 1'b0;
        w_placed    = 1'b0;
        w_lane      = '0;
        w_pts       = '0;
        w_nhit      = '0;
        w_yext      = '0;
        w_d         = '0;
        if (enable_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (btn_i[k]) begin
                    w_found = 1'b0;
                    for (int unsigned s = 0; s < SLOTS; s++) begin
                        w_yext = {1'b0, r_y[k*SLOTS+s]};
                        w_d    = (w_yext >= TY) ? (w_yext - TY) : (TY - w_yext);
                        if (!w_found && r_valid[k*SLOTS+s] && (w_d <= HWIN)) begin
                            w_found                 = 1'b1;
                            w_valid_nxt[k*SLOTS+s]  = 1'b0;
                            w_hit[k]                = 1'b1;
                            w_nhit                  = w_nhit + HITW'(1);
                            w_pts = w_pts + ((w_d <= PWIN) ? PTSW'(3) : PTSW'(1));
                        end
                    end
                    w_boo[k] = !w_found;
                end
            end
            if (frame_i) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    for (int unsigned s = 0; s < SLOTS; s++) begin
                        if (w_valid_nxt[k*SLOTS+s]) begin
                            w_yext = {1'b0, r_y[k*SLOTS+s]} + SPD;
                            if (w_yext > MISS_Y) begin
                                w_valid_nxt[k*SLOTS+s] = 1'b0;
                                w_miss[k]              = 1'b1;
                            end else begin
                                w_y_nxt[k*SLOTS+s] = w_yext[CORDW-1:0];
                            end
                        end
                    end
                end
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
                    w_lane     = 3'(32'(w_lfsr_nxt[7:0]) % LANES);
                    for (int unsigned k = 0; k < LANES; k++) begin
                        for (int unsigned s = 0; s < SLOTS; s++) begin
                            if ((3'(k) == w_lane) && !w_placed && !w_valid_nxt[k*SLOTS+s]) begin
                                w_placed               = 1'b1;
                                w_valid_nxt[k*SLOTS+s] = 1'b1;
                                w_y_nxt[k*SLOTS+s]     = '0;
                            end
                        end
                    end
                    w_spawn = w_placed;
                    w_drop  = !w_placed;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
        end
    end

    // Saturating score and combo; any boo or miss breaks the combo
    always_comb begin
        w_score_sum = {1'b0, r_score} + (SCOREW+1)'(w_pts);
        w_combo_sum = {1'b0, r_combo} + (COMBOW+1)'(w_nhit);
        w_score_nxt = w_score_sum[SCOREW] ? '1 : w_score_sum[SCOREW-1:0];
        w_combo_nxt = w_combo_sum[COMBOW] ? '1 : w_combo_sum[COMBOW-1:0];
        if ((|w_boo) || (|w_miss)) begin
            w_combo_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid      <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_y[i] <= '0;
            end
            r_cnt        <= '0;
            r_lfsr       <= LFSR_SEED;
            r_score      <= '0;
            r_combo      <= '0;
            r_hit        <= '0;
            r_boo        <= '0;
            r_miss       <= '0;
            r_spawn      <= 1'b0;
            r_drop       <= 1'b0;
            r_spawn_lane <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_y[i] <= w_y_nxt[i];
            end
            r_cnt   <= w_cnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_score <= w_score_nxt;
            r_combo <= w_combo_nxt;
            r_hit   <= w_hit;
            r_boo   <= w_boo;
            r_miss  <= w_miss;
            r_spawn <= w_spawn;
            r_drop  <= w_drop;
            if (w_spawn) begin
                r_spawn_lane <= w_lane;
            end
        end
    end

    // Pixel hit tests for the paint mux
    always_comb begin
        w_in_lane = '0;
        arrow_o   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_in_lane[k] = (32'(sx_i) >= LANE_X0 + k * LANE_PITCH) &&
                           (32'(sx_i) <  LANE_X0 + k * LANE_PITCH + ARROW_W);
            for (int unsigned s = 0; s < SLOTS; s++) begin
                arrow_o[k*SLOTS+s] = r_valid[k*SLOTS+s] && w_in_lane[k] &&
                                     (32'(sy_i) >= 32'(r_y[k*SLOTS+s])) &&
                                     (32'(sy_i) <  32'(r_y[k*SLOTS+s]) + ARROW_H);
            end
        end
        target_o = (|w_in_lane) && (32'(sy_i) >= TARGET_Y) &&
                   (32'(sy_i) < TARGET_Y + ARROW_H);
    end

    assign hit_o        = r_hit;
    assign boo_o        = r_boo;
    assign miss_o       = r_miss;
    assign spawn_o      = r_spawn;
    assign spawn_lane_o = r_spawn_lane;
    assign drop_o       = r_drop;
    assign score_o      = r_score;
    assign combo_o      = r_combo;

endmodule

// File: tb/tb_ddr_lane_engine.sv
// Directed bench for ddr_lane_engine: three parameterisations exercising
// spawn/scroll, judging, misses, and lane-full drops.
module tb_ddr_lane_engine;

    logic       clk;
    logic       rst_n;
    logic [9:0] sx, sy;
    logic       frame, enable;
    logic [3:0] btn;

    logic [15:0] a_arrow, b_arrow;
    logic [3:0]  c_arrow;
    logic        a_target, b_target, c_target;
    logic [3:0]  a_hit, a_boo, a_miss, b_hit, b_boo, b_miss;
    logic [0:0]  c_hit, c_boo, c_miss;
    logic        a_spawn, b_spawn, c_spawn, a_drop, b_drop, c_drop;
    logic [2:0]  a_lane, b_lane, c_lane;
    logic [15:0] a_score, b_score, c_score;
    logic [7:0]  a_combo, b_combo, c_combo;

    int checks = 0;
    int errors = 0;

    ddr_lane_engine #(.SPAWN_PERIOD(4)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .sx_i(sx), .sy_i(sy), .frame_i(frame),
        .enable_i(enable), .btn_i(btn), .arrow_o(a_arrow), .target_o(a_target),
        .hit_o(a_hit), .boo_o(a_boo), .miss_o(a_miss), .spawn_o(a_spawn),
        .spawn_lane_o(a_lane), .drop_o(a_drop), .score_o(a_score), .combo_o(a_combo));

    ddr_lane_engine #(.SPAWN_PERIOD(256)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .sx_i(sx), .sy_i(sy), .frame_i(frame),
        .enable_i(enable), .btn_i(btn), .arrow_o(b_arrow), .target_o(b_target),
        .hit_o(b_hit), .boo_o(b_boo), .miss_o(b_miss), .spawn_o(b_spawn),
        .spawn_lane_o(b_lane), .drop_o(b_drop), .score_o(b_score), .combo_o(b_combo));

    ddr_lane_engine #(.LANES(1), .SLOTS(4), .SPAWN_PERIOD(1)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .sx_i(sx), .sy_i(sy), .frame_i(frame),
        .enable_i(enable), .btn_i(btn[0]), .arrow_o(c_arrow), .target_o(c_target),
        .hit_o(c_hit), .boo_o(c_boo), .miss_o(c_miss), .spawn_o(c_spawn),
        .spawn_lane_o(c_lane), .drop_o(c_drop), .score_o(c_score), .combo_o(c_combo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frames(input int n);
        frame = 1'b1;
        repeat (n) tick();
        frame = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic pix(input int x, input int y);
        sx = 10'(x);
        sy = 10'(y);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        btn = m;
        tick();
        btn = '0;
    endtask

    task automatic test_reset();
        do_reset();
        pix(160, 0);
        checks++; if (a_arrow !== 16'h0) begin errors++; $display("FAIL reset_arrow got=%h exp=0", a_arrow); end
        checks++; if (a_score !== 16'd0 || a_combo !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d/%0d exp=0/0", a_score, a_combo); end
        checks++; if ({a_spawn, a_drop, a_hit, a_boo, a_miss, a_lane} !== '0) begin errors++; $display("FAIL reset_pulses got spawn=%b drop=%b hit=%b boo=%b miss=%b lane=%0d", a_spawn, a_drop, a_hit, a_boo, a_miss, a_lane); end
    endtask

    task automatic test_spawn_scroll();
        do_frames(3);
        checks++; if (a_spawn !== 1'b0) begin errors++; $display("FAIL early_spawn got=%b exp=0", a_spawn); end
        do_frames(1);
        checks++; if (a_spawn !== 1'b1 || a_lane !== 3'd0 || a_drop !== 1'b0) begin errors++; $display("FAIL spawn4 got spawn=%b lane=%0d drop=%b exp 1/0/0", a_spawn, a_lane, a_drop); end
        tick();
        checks++; if (a_spawn !== 1'b0) begin errors++; $display("FAIL spawn_pulse_len got=%b exp=0", a_spawn); end
        do_frames(10);
        pix(160, 20);
        checks++; if (a_arrow !== 16'h0007) begin errors++; $display("FAIL pix_sy20 got=%h exp=0007", a_arrow); end
        pix(160, 51);
        checks++; if (a_arrow !== 16'h0001) begin errors++; $display("FAIL pix_sy51 got=%h exp=0001", a_arrow); end
        pix(160, 19);
        checks++; if (a_arrow !== 16'h0006) begin errors++; $display("FAIL pix_sy19 got=%h exp=0006", a_arrow); end
        pix(160, 52);
        checks++; if (a_arrow !== 16'h0000) begin errors++; $display("FAIL pix_sy52 got=%h exp=0000", a_arrow); end
        pix(224, 20);
        checks++; if (a_arrow !== 16'h0000) begin errors++; $display("FAIL pix_xedge got=%h exp=0000", a_arrow); end
        pix(160, 400);
        checks++; if (a_target !== 1'b1) begin errors++; $display("FAIL target_in got=%b exp=1", a_target); end
        pix(160, 432);
        checks++; if (a_target !== 1'b0) begin errors++; $display("FAIL target_ybot got=%b exp=0", a_target); end
        pix(256, 400);
        checks++; if (a_target !== 1'b1) begin errors++; $display("FAIL target_lane1 got=%b exp=1", a_target); end
        pix(240, 400);
        checks++; if (a_target !== 1'b0) begin errors++; $display("FAIL target_gap got=%b exp=0", a_target); end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        pix(160, 20);
        checks++; if (a_arrow !== 16'h0 || a_score !== 16'd0 || a_combo !== 8'd0 || a_spawn !== 1'b0) begin errors++; $display("FAIL midreset got arrow=%h score=%0d combo=%0d spawn=%b", a_arrow, a_score, a_combo, a_spawn); end
        do_frames(16);
        checks++; if (a_spawn !== 1'b1 || a_lane !== 3'd2) begin errors++; $display("FAIL lfsr_restart got spawn=%b lane=%0d exp 1/2", a_spawn, a_lane); end
        pix(352, 0);
        checks++; if (a_arrow !== 16'h0100) begin errors++; $display("FAIL lane2_arrow got=%h exp=0100", a_arrow); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        frame  = 1'b1;
        btn    = 4'hF;
        tick();
        frame  = 1'b0;
        btn    = '0;
        checks++; if (a_boo !== 4'h0 || a_hit !== 4'h0 || a_spawn !== 1'b0) begin errors++; $display("FAIL disabled_pulses got boo=%b hit=%b spawn=%b exp 0", a_boo, a_hit, a_spawn); end
        pix(352, 0);
        checks++; if (a_arrow !== 16'h0100) begin errors++; $display("FAIL disabled_frozen got=%h exp=0100", a_arrow); end
        enable = 1'b1;
    endtask

    task automatic test_hits();
        do_reset();
        do_frames(456);
        pix(160, 400);
        checks++; if (b_arrow !== 16'h0001) begin errors++; $display("FAIL arrow_at_400 got=%h exp=0001", b_arrow); end
        press(4'b0001);
        checks++; if (b_hit !== 4'b0001 || b_boo !== 4'b0 || b_score !== 16'd3 || b_combo !== 8'd1) begin errors++; $display("FAIL perfect got hit=%b boo=%b score=%0d combo=%0d exp 0001/0000/3/1", b_hit, b_boo, b_score, b_combo); end
        checks++; if (b_arrow !== 16'h0000) begin errors++; $display("FAIL perfect_clear got=%h exp=0000", b_arrow); end
        tick();
        checks++; if (b_hit !== 4'b0) begin errors++; $display("FAIL hit_pulse_len got=%b exp=0000", b_hit); end
        do_frames(261);
        pix(160, 410);
        checks++; if (b_arrow !== 16'h0001) begin errors++; $display("FAIL arrow_at_410 got=%h exp=0001", b_arrow); end
        press(4'b0001);
        checks++; if (b_hit !== 4'b0001 || b_score !== 16'd4 || b_combo !== 8'd2) begin errors++; $display("FAIL good got hit=%b score=%0d combo=%0d exp 0001/4/2", b_hit, b_score, b_combo); end
    endtask

    task automatic test_boo();
        press(4'b0010);
        checks++; if (b_boo !== 4'b0010 || b_hit !== 4'b0 || b_score !== 16'd4 || b_combo !== 8'd0) begin errors++; $display("FAIL boo got boo=%b hit=%b score=%0d combo=%0d exp 0010/0000/4/0", b_boo, b_hit, b_score, b_combo); end
        tick();
        checks++; if (b_boo !== 4'b0) begin errors++; $display("FAIL boo_pulse_len got=%b exp=0000", b_boo); end
    endtask

    task automatic test_simultaneous();
        do_frames(259);
        pix(160, 416);
        checks++; if (b_arrow !== 16'h0001) begin errors++; $display("FAIL arrow_at_416 got=%h exp=0001", b_arrow); end
        frame = 1'b1;
        btn   = 4'b0001;
        tick();
        frame = 1'b0;
        btn   = '0;
        checks++; if (b_hit !== 4'b0001 || b_miss !== 4'b0 || b_score !== 16'd5 || b_combo !== 8'd1) begin errors++; $display("FAIL simul got hit=%b miss=%b score=%0d combo=%0d exp 0001/0000/5/1", b_hit, b_miss, b_score, b_combo); end
        pix(160, 418);
        checks++; if (b_arrow !== 16'h0000) begin errors++; $display("FAIL simul_clear got=%h exp=0000", b_arrow); end
    endtask

    task automatic test_miss();
        do_frames(255);
        pix(352, 416);
        checks++; if (b_arrow !== 16'h0100 || b_lane !== 3'd2) begin errors++; $display("FAIL pre_miss got arrow=%h lane=%0d exp 0100/2", b_arrow, b_lane); end
        do_frames(1);
        checks++; if (b_miss !== 4'b0100 || b_hit !== 4'b0 || b_combo !== 8'd0 || b_score !== 16'd5) begin errors++; $display("FAIL miss got miss=%b hit=%b combo=%0d score=%0d exp 0100/0000/0/5", b_miss, b_hit, b_combo, b_score); end
        checks++; if (b_arrow !== 16'h0000) begin errors++; $display("FAIL miss_clear got=%h exp=0000", b_arrow); end
        tick();
        checks++; if (b_miss !== 4'b0) begin errors++; $display("FAIL miss_pulse_len got=%b exp=0000", b_miss); end
    endtask

    task automatic test_lane_full();
        do_reset();
        do_frames(4);
        checks++; if (c_spawn !== 1'b1 || c_drop !== 1'b0) begin errors++; $display("FAIL fourth_spawn got spawn=%b drop=%b exp 1/0", c_spawn, c_drop); end
        do_frames(1);
        checks++; if (c_drop !== 1'b1 || c_spawn !== 1'b0 || c_lane !== 3'd0) begin errors++; $display("FAIL drop got drop=%b spawn=%b lane=%0d exp 1/0/0", c_drop, c_spawn, c_lane); end
        pix(160, 8);
        checks++; if (c_arrow !== 4'b1111) begin errors++; $display("FAIL full_sy8 got=%b exp=1111", c_arrow); end
        pix(160, 7);
        checks++; if (c_arrow !== 4'b1110) begin errors++; $display("FAIL full_sy7 got=%b exp=1110", c_arrow); end
        pix(160, 2);
        checks++; if (c_arrow !== 4'b1000) begin errors++; $display("FAIL full_sy2 got=%b exp=1000", c_arrow); end
        tick();
        checks++; if (c_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_len got=%b exp=0", c_drop); end
    endtask

    initial begin
        rst_n  = 1'b1;
        sx     = '0;
        sy     = '0;
        frame  = 1'b0;
        enable = 1'b1;
        btn    = '0;
        test_reset();
        test_spawn_scroll();
        test_reset_midgame();
        test_enable();
        test_hits();
        test_boo();
        test_simultaneous();
        test_miss();
        test_lane_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
